data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Word-addressed data memory sitting on the responder side of the control unit's memory-strobe interface. It samples the active-low `memRead` / `memWrite` strobes driven by `control`, runs one access at a time with a fixed, parameterised latency, and returns read data with a single-cycle `ready` completion pulse. Illegal requests raise `error`:
- simultaneous strobes,
- out-of-range address,
- misaligned address (when enabled).

## Interface
Parameters:
- ADDR_WIDTH, 8, word-index bits; depth = 2^ADDR_WIDTH 32-bit words
- LATENCY, 2, edges from request acceptance to completion; legal range 1..15

Ports:
- clock  in  1  rising-edge clock; only clock
- reset  in  1  synchronous, active-high reset
- memRead  in  1  read strobe, active-low (0 = read request)
- memWrite  in  1  write strobe, active-low (0 = write request)
- address  in  32  byte address; word index = address[ADDR_WIDTH+1:2]
- writeData  in  32  store data, sampled with the write request
- readData  out  32  load data; holds its value between completions
- ready  out  1  one-cycle pulse at access completion
- busy  out  1  high while an accepted access is pending
- error  out  1  one-cycle pulse flagging an illegal request

## Operation
- States are IDLE and WAIT, plus a 4-bit countdown `cnt`.
- **IDLE, rising edge:**
  - memRead=0 and memWrite=0 together: conflict. Pulse `error` next cycle, no access, stay in IDLE.
  - memRead=0 only: latch address, set op=read, cnt=LATENCY-1, go to WAIT, busy=1.
  - memWrite=0 only: latch address and writeData, set op=write, cnt=LATENCY-1, go to WAIT, busy=1.
  - Both strobes high: remain in IDLE.
- **WAIT:**
  - While cnt≠0: decrement cnt. Strobes are ignored; requests are not queued.
  - At the edge where cnt=0, perform the latched op:
    - read: readData ← mem[index]
    - write: mem[index] ← latched data
  - At that same edge: ready=1 for one cycle, busy=0, return to IDLE.
- **Range check:** if address[31:ADDR_WIDTH+2] ≠ 0, the access is suppressed.
  - No write occurs; readData is forced to 0.
  - `ready` and `error` pulse together at the normal completion edge. Latency is unchanged.
- **Reset:**
  - State → IDLE, cnt=0, readData=0, ready=0, busy=0, error=0.
  - Memory contents are preserved, not cleared.
  - Reset during WAIT abandons the access. A pending write is never committed, and no ready pulse occurs.
- Inputs are not re-sampled after acceptance. Address or data changes during WAIT have no effect.

## Timing
- Request accepted at edge N:
  - busy=1 in cycles N..N+LATENCY-1 (i.e. after edges N through N+LATENCY-1).
  - Completion at edge N+LATENCY: ready=1, busy=0, and readData valid in that same cycle.
- The completion edge does not accept a new request. The earliest next acceptance is edge N+LATENCY+1, so peak throughput is one access per LATENCY+1 cycles.
- A conflict error is reported at edge N (error=1 in cycle after N), with no busy phase. The next request can be accepted at edge N+1.
- A strobe held low across completion is accepted again at edge N+LATENCY+1. Callers must deassert it to avoid a repeat.
- readData changes only on a read completion or on reset.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - address[1:0] ≠ 0 is treated exactly like out-of-range: suppressed access, readData=0 for reads, and ready+error pulse at completion.
- Undefined:
  - address[1:0] is ignored and the access proceeds to the word containing the byte.

## Test plan
- **Reset then write/read, LATENCY=2:** reset; write 0xDEADBEEF to 0x10; wait for ready; read 0x10.
  - Expect busy high for 2 cycles, ready pulse at edge N+2, readData=0xDEADBEEF, error=0.
- **Simultaneous strobes:** memRead=0 and memWrite=0 at the same edge.
  - Expect error=1 for one cycle, busy=0, ready=0, memory and readData unchanged.
- **Out-of-range, ADDR_WIDTH=8:** read 0x400.
  - Expect ready and error pulse together at N+2, readData=0. A write to 0x400 leaves every word unchanged.
- **Reset mid-write:** write 0x12345678 to 0x20; assert reset at edge N+1; then read 0x20.
  - Expect the old value, and no ready pulse for the aborted write.
- **Back-to-back with strobes held low:** memRead=0 held continuously at LATENCY=1.
  - Expect ready pulses every 2 cycles and busy never high on completion cycles.
- **Misaligned read of 0x13, with word 0x10 = 0xCAFEF00D:**
  - `DMEM_ALIGN_CHECK_EN` defined: error+ready, readData=0.
  - Undefined: readData=0xCAFEF00D, error=0.

Source files
------------

// File: rtl/data_memory_responder.sv
// Word-addressed data memory answering active-low memRead/memWrite strobes with fixed latency.
// Optional misaligned-address rejection: define DMEM_ALIGN_CHECK_EN.
module data_memory_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        busy,
    output logic        error
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_is_write;
    logic                  r_bad;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [31:0]           r_wdata;
    logic [31:0]           r_mem [DEPTH];

    logic w_req_rd;
    logic w_req_wr;
    logic w_conflict;
    logic w_range_bad;
    logic w_bad;
    logic w_done;

    assign w_req_rd    = ~memRead & memWrite;
    assign w_req_wr    = memRead & ~memWrite;
    assign w_conflict  = ~memRead & ~memWrite;
    assign w_range_bad = |address[31:ADDR_WIDTH+2];
    assign w_done      = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_bad = w_range_bad | (|address[1:0]);
`else
    // Byte offset is dropped: the access goes to the containing word.
    logic w_unused_offset;
    assign w_unused_offset = &{1'b0, address[1:0]};
    assign w_bad = w_range_bad;
`endif

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (!reset && w_done && r_is_write && !r_bad) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_bad      <= 1'b0;
            r_index    <= '0;
            r_wdata    <= 32'd0;
            readData   <= 32'd0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            ready <= 1'b0;
            error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_conflict) begin
                        error <= 1'b1;
                    end else if (w_req_rd || w_req_wr) begin
                        r_state    <= S_WAIT;
                        r_cnt      <= CNT_INIT;
                        r_is_write <= w_req_wr;
                        r_bad      <= w_bad;
                        r_index    <= address[ADDR_WIDTH+1:2];
                        r_wdata    <= writeData;
                        busy       <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_is_write) begin
                            readData <= r_bad ? 32'd0 : r_mem[r_index];
                        end
                        ready   <= 1'b1;
                        error   <= r_bad;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: table vectors, corner sequences,
// and random traffic against an array-based memory model.
module tb_data_memory_responder;
    localparam int AW  = 8;
    localparam int LAT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        memRead, memWrite;
    logic [31:0] address, writeData, readData;
    logic        ready, busy, error;

    logic        memRead1, memWrite1;
    logic [31:0] address1, writeData1, readData1;
    logic        ready1, busy1, error1;

    data_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u_dut (
        .clock(clock), .reset(reset),
        .memRead(memRead), .memWrite(memWrite),
        .address(address), .writeData(writeData),
        .readData(readData), .ready(ready), .busy(busy), .error(error)
    );

    data_memory_responder #(.ADDR_WIDTH(4), .LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .memRead(memRead1), .memWrite(memWrite1),
        .address(address1), .writeData(writeData1),
        .readData(readData1), .ready(ready1), .busy(busy1), .error(error1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem [256];
    logic [31:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        return ((a >> (AW + 2)) != 0) || (ALIGN && (a[1:0] != 2'b00));
    endfunction

    // op: 0 read, 1 write, 2 conflicting strobes. Called and returns at a negedge.
    task automatic access(input int op, input logic [31:0] a, input logic [31:0] wd,
                          output logic act_err, output logic [31:0] act_rd);
        bit          bad;
        int unsigned idx;
        bad = is_bad(a);
        idx = (a >> 2) & 32'hFF;
        address   = a;
        writeData = wd;
        memRead   = (op == 1);
        memWrite  = (op == 0);
        if (op == 2) begin
            memRead  = 1'b0;
            memWrite = 1'b0;
        end
        @(posedge clock); @(negedge clock);
        memRead  = 1'b1;
        memWrite = 1'b1;
        address  = $urandom;
        writeData = $urandom;
        if (op == 2) begin
            chk("conflict_err", {31'd0, error}, 32'd1);
            chk("conflict_busy", {30'd0, busy, ready}, 32'd0);
            chk("conflict_rd", readData, m_rd);
            act_err = error;
            act_rd  = readData;
        end else begin
            chk("busy_start", {30'd0, busy, ready}, 32'd2);
            for (int k = 1; k < LAT; k++) begin
                @(posedge clock); @(negedge clock);
                chk("busy_hold", {30'd0, busy, ready}, 32'd2);
            end
            @(posedge clock); @(negedge clock);
            if (op == 0) m_rd = bad ? 32'd0 : m_mem[idx];
            else if (!bad) m_mem[idx] = wd;
            chk("done_rdy_busy", {30'd0, busy, ready}, 32'd1);
            chk("done_err", {31'd0, error}, {31'd0, bad});
            chk("done_rd", readData, m_rd);
            act_err = error;
            act_rd  = readData;
        end
        @(posedge clock); @(negedge clock);
        chk("after_idle", {29'd0, busy, ready, error}, 32'd0);
    endtask

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        tbl [8];
    logic        e;
    logic [31:0] r;
    logic [31:0] old;

    initial begin
        reset = 1'b1;
        memRead = 1'b1; memWrite = 1'b1; address = 0; writeData = 0;
        memRead1 = 1'b1; memWrite1 = 1'b1; address1 = 0; writeData1 = 0;
        m_rd = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_rd", readData, 32'd0);
        chk("rst_flags", {29'd0, busy, ready, error}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) begin
            access(1, i * 4, (i * 32'h01010101) ^ 32'h5A5A0F0F, e, r);
        end

        // Hand-computed vectors; the trailing DEADBEEF/CAFEF00D entries are independent of the model.
        tbl[0] = '{1, 32'h10,  32'hDEADBEEF, 1'b0, 32'd0};
        tbl[1] = '{0, 32'h10,  32'd0,        1'b0, 32'hDEADBEEF};
        tbl[2] = '{0, 32'h400, 32'd0,        1'b1, 32'd0};
        tbl[3] = '{1, 32'h0,   32'h11111111, 1'b0, 32'd0};
        tbl[4] = '{1, 32'h400, 32'h99999999, 1'b1, 32'd0};
        tbl[5] = '{0, 32'h0,   32'd0,        1'b0, 32'h11111111};
        tbl[6] = '{1, 32'h10,  32'hCAFEF00D, 1'b0, 32'h11111111};
        tbl[7] = '{0, 32'h13,  32'd0, ALIGN, ALIGN ? 32'd0 : 32'hCAFEF00D};
        for (int i = 0; i < 8; i++) begin
            access(tbl[i].op, tbl[i].addr, tbl[i].wdata, e, r);
            chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
            chk($sformatf("tbl%0d_rd", i), r, tbl[i].exp_rd);
        end

        old = m_rd;
        access(2, 32'h10, 32'h0BAD0BAD, e, r);
        chk("conflict_keep_rd", r, old);
        access(0, 32'h10, 32'd0, e, r);
        chk("conflict_mem", r, 32'hCAFEF00D);

        // Reset one edge into a write: nothing commits, no ready.
        old = m_mem[8];
        address = 32'h20; writeData = 32'h12345678; memWrite = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("midwr_busy", {31'd0, busy}, 32'd1);
        memWrite = 1'b1;
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("midwr_rst", {29'd0, busy, ready, error}, 32'd0);
        reset = 1'b0;
        m_rd = 32'd0;
        chk("midwr_rd0", readData, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); @(negedge clock);
            chk("midwr_noready", {29'd0, busy, ready, error}, 32'd0);
        end
        access(0, 32'h20, 32'd0, e, r);
        chk("midwr_old", r, old);

        // LATENCY=1 instance with read strobe held low.
        address1 = 32'h0; writeData1 = 32'h55AA0001; memWrite1 = 1'b0;
        @(posedge clock); @(negedge clock);
        memWrite1 = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("l1_wr_done", {29'd0, busy1, ready1, error1}, 32'd2);
        memRead1 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock); @(negedge clock);
            if (c % 2 == 1) begin
                chk("held_busy", {30'd0, busy1, ready1}, 32'd2);
            end else begin
                chk("held_ready", {30'd0, busy1, ready1}, 32'd1);
                chk("held_rd", readData1, 32'h55AA0001);
            end
        end
        memRead1 = 1'b1;

        for (int i = 0; i < 300; i++) begin
            int          op;
            int          sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            op  = (sel == 0) ? 2 : (sel < 5) ? 1 : 0;
            a   = $urandom_range(0, 255) * 4;
            sel = $urandom_range(0, 9);
            if (sel == 0) a = a | (32'h400 << $urandom_range(0, 21));
            else if (sel == 1) a = a | $urandom_range(1, 3);
            access(op, a, $urandom, e, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
